xif_mem_responder: RTL

Core-side responder for the CORE-V-XIF memory and memory-result interfaces. It accepts load and store requests issued by the rvfpm coprocessor, performs them against an internal word-organised memory, and returns exactly one in-order mem_result per accepted request after a fixed latency. The bench drives rvfpm through this block in place of a real core LSU. It also supplies parameterised backpressure to exercise the coprocessor's mem handshake.

---
 rtl/xif_mem_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/xif_mem_responder.sv
// xif_mem_responder: core-side responder for the CORE-V-XIF mem / mem_result
// interfaces. It serves loads and stores from an internal word memory and
// returns one in-order result per accepted request after MEM_LATENCY cycles.
// Optional periodic backpressure drops mem_ready for one cycle after every
// STALL_EVERY-th accept.
module xif_mem_responder #(
  parameter int X_ID_WIDTH  = 4,
  parameter int XLEN        = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 2,
  parameter int STALL_EVERY = 0
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [X_ID_WIDTH-1:0] mem_req_id,
  input  logic [XLEN-1:0]       mem_req_addr,
  input  logic [1:0]            mem_req_mode,
  input  logic                  mem_req_we,
  input  logic [2:0]            mem_req_size,
  input  logic [XLEN/8-1:0]     mem_req_be,
  input  logic [1:0]            mem_req_attr,
  input  logic [XLEN-1:0]       mem_req_wdata,
  input  logic                  mem_req_last,
  input  logic                  mem_req_spec,
  output logic                  mem_result_valid,
  output logic [X_ID_WIDTH-1:0] mem_result_id,
  output logic [XLEN-1:0]       mem_result_rdata,
  output logic                  mem_result_err,
  output logic                  mem_result_dbg
);

  localparam int NB = XLEN / 8;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       rdata;
    logic                  err;
  } stage_t;

  logic [XLEN-1:0] mem_array [MEM_DEPTH];

  logic [MEM_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  stage_t [MEM_LATENCY-1:0] pipe_q, pipe_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stall_q, stall_d;

  logic            accept;
  logic [XLEN-3:0] word_idx;
  logic            in_range;
  logic            align_err;
  logic            req_err;
  logic [AW-1:0]   idx;
  logic            wr_en;

  // Mode, attr, last and spec carry no meaning for this responder.
  logic unused_ok;
  assign unused_ok = ^{mem_req_mode, mem_req_attr, mem_req_last, mem_req_spec};

  // No combinational path from mem_valid; rst_n gating keeps the reset edge
  // from accepting or writing anything.
  assign mem_ready = enable && !stall_q;
  assign accept    = mem_valid && mem_ready && rst_n;

  // Request decode: word index, range and alignment checks.
  always_comb begin
    word_idx  = mem_req_addr[XLEN-1:2];
    in_range  = ({2'b00, word_idx} < XLEN'(MEM_DEPTH));
    align_err = 1'b0;
    case (mem_req_size)
      3'd0:    align_err = 1'b0;
      3'd1:    align_err = mem_req_addr[0];
      3'd2:    align_err = (mem_req_addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
    req_err = align_err || !in_range;
    // Clamp so an out-of-range request never indexes past the array.
    idx     = in_range ? word_idx[AW-1:0] : '0;
    wr_en   = accept && mem_req_we && !req_err;
  end

  // Byte-lane store into the uninitialised word memory.
  always_ff @(posedge ck) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_req_be[b]) mem_array[idx][8*b +: 8] <= mem_req_wdata[8*b +: 8];
      end
    end
  end

  // Result delay line and backpressure counter next-state.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    pipe_d     = pipe_q;
    cnt_d      = cnt_q;
    stall_d    = 1'b0;
    // Stage 0 payload is zeroed when nothing is accepted so idle stages never
    // carry stale or uninitialised memory data.
    vld_pipe_d[0]     = accept;
    pipe_d[0].id      = accept ? mem_req_id : '0;
    pipe_d[0].err     = accept && req_err;
    pipe_d[0].rdata   = (accept && !mem_req_we && !req_err) ? mem_array[idx] : '0;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      pipe_d[i]     = pipe_q[i-1];
    end
    if (STALL_EVERY > 0 && accept) begin
      if (cnt_q == CW'(STALL_EVERY - 1)) begin
        cnt_d   = '0;
        stall_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pipeline and stall state registers with synchronous reset.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      pipe_q     <= '0;
      cnt_q      <= '0;
      stall_q    <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      pipe_q     <= pipe_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign mem_result_valid = vld_pipe_q[MEM_LATENCY-1];
  assign mem_result_id    = pipe_q[MEM_LATENCY-1].id;
  assign mem_result_rdata = pipe_q[MEM_LATENCY-1].rdata;
  assign mem_result_err   = pipe_q[MEM_LATENCY-1].err;
  assign mem_result_dbg   = 1'b0;

endmodule
